jt51_noise_ctrl: RTL and testbench
==================================

// Module: jt51_noise_ctrl
// PURPOSE
//  Sequencer for the 17-bit noise LFSR. Divides the sample-rate tick by the
//  NFRQ register value and toggles the LFSR 'base' input once per noise period.
//  Latches the post-shift LFSR bit and gates it with NE for the op-4/ch-8 noise slot.
//  Sits between the register file (reg 0x0F: NE, NFRQ) and the LFSR instance.
//  Also owns the LFSR reset: holds it in reset for a fixed count after rst_n releases.
// PARAMETERS
//  CNT_W     5   divider width; must cover the NFRQ field width
//  INIT_CYC  2   clk cycles lfsr_rst stays high after rst_n deasserts (range 1..15)
// PORTS
//  clk        in   1      system clock, single clock domain
//  rst_n      in   1      asynchronous, active-low reset
//  cen        in   1      clock enable; all state advances only when cen=1
//  zero       in   1      sample-boundary strobe; valid only when cen=1
//  ne         in   1      noise enable (reg 0x0F bit 7)
//  nfrq       in   CNT_W  noise frequency (reg 0x0F bits 4:0)
//  nfrq_wr    in   1      one-cen strobe marking a write to reg 0x0F
//  lfsr_out   in   1      LFSR output bit (bb[16])
//  lfsr_rst   out  1      synchronous active-high reset for the LFSR
//  base       out  1      LFSR step control; each level change = one shift
//  noise_bit  out  1      latched noise bit, forced to 0 when ne=0
//  noise_upd  out  1      one-cen pulse when noise_bit takes a new LFSR value
// BEHAVIOUR
//  Reset (rst_n=0, async):
//   - state=INIT, cnt=0, base=0, noise_q=0, noise_upd=0, lfsr_rst=1, init_cnt=0.
//  INIT:
//   - lfsr_rst=1. init_cnt increments every clk, not gated by cen.
//   - On init_cnt==INIT_CYC-1: lfsr_rst<=0, cnt<=nfrq, go to COUNT.
//  COUNT (cen=1 and zero=1):
//   - cnt==all-ones: toggle base, cnt<=nfrq, go to SHIFT.
//   - Otherwise: cnt<=cnt+1.
//   - Period is (2^CNT_W - nfrq) sample ticks. nfrq=31 steps every tick.
//     nfrq=0 steps every 32 ticks.
//  SHIFT:
//   - The LFSR shifts on the clk after the base toggle.
//   - Go to CAPTURE on the next cen=1 cycle. No zero is needed.
//  CAPTURE (cen=1):
//   - noise_q<=lfsr_out, noise_upd=1 for this one cen cycle, go to COUNT.
//  Outputs:
//   - noise_bit = ne & noise_q, combinational, so NE takes effect immediately.
//   - Latency from the qualifying zero tick to noise_upd is 2 cen cycles.
//  Register write:
//   - nfrq_wr in COUNT reloads cnt<=nfrq. This takes priority over a
//     simultaneous zero increment.
//   - nfrq_wr in SHIFT or CAPTURE is held in a pending flag. The flag is
//     applied as the reload on entry to COUNT, overriding the reload done in COUNT.
//  Free-running:
//   - ne=0 does not stop the divider or the LFSR, so the noise phase stays
//     continuous. Only noise_bit is masked.
//  Wrap-around:
//   - cnt arithmetic is modulo 2^CNT_W. No saturation.
//  Reset mid-operation:
//   - rst_n low in any state returns to INIT immediately. base returns to 0.
//   - The LFSR is reloaded to its init value through lfsr_rst.
//  Gating:
//   - cen=0 freezes all state except init_cnt. zero is ignored outside COUNT.
// STRUCTURE
//  Shared package jt51_pkg:
//   - state enum {INIT, COUNT, SHIFT, CAPTURE} (2 bits).
//   - NFRQ field width constant (=5). REG_NOISE address constant 8'h0F.
//  Single level, no sub-modules:
//   - One always block for the async-reset FSM and counters.
//   - Continuous assign for noise_bit.
//   - The LFSR is instantiated by the parent, next to this block.
// TESTING
//  1. Reset release with INIT_CYC=2 -> lfsr_rst high exactly 2 clk after rst_n
//     rises. base=0 and noise_bit=0 throughout.
//  2. nfrq=31, ne=1, zero every 32 cen -> base toggles every zero. noise_upd
//     2 cen later. noise_bit matches the LFSR sequence from init 14220.
//  3. nfrq=0 -> exactly 32 zero ticks between base toggles. nfrq=28 -> 4 ticks.
//  4. ne toggled 1->0->1 mid-period -> noise_bit drops to 0 the same cycle.
//     Divider phase is unchanged: the next base toggle lands on the predicted tick.
//  5. nfrq_wr with nfrq=30 on the same cen as zero in COUNT -> cnt=30, no
//     increment. Base toggles 2 ticks later. Same write during SHIFT -> applied
//     on entry to COUNT.
//  6. rst_n pulsed low while in SHIFT -> immediate INIT, base=0. LFSR sequence
//     restarts from the init value after INIT_CYC cycles.

Source files
------------

// File: rtl/jt51_pkg.sv
// Shared definitions for the jt51 noise path: register address, field width
// and the noise sequencer state encoding.
package jt51_pkg;

  localparam int NFRQ_W = 5;
  localparam logic [7:0] REG_NOISE = 8'h0F;

  typedef enum logic [1:0] {
    INIT    = 2'd0,
    COUNT   = 2'd1,
    SHIFT   = 2'd2,
    CAPTURE = 2'd3
  } noise_state_e;

endpackage

// File: rtl/jt51_noise_ctrl.sv
// Noise sequencer: divides sample ticks by (2^CNT_W - nfrq), steps the LFSR via
// 'base' toggles, latches the shifted bit and owns the LFSR power-up reset.
module jt51_noise_ctrl
  import jt51_pkg::*;
#(
  parameter int CNT_W    = NFRQ_W,
  parameter int INIT_CYC = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cen,
  input  logic             zero,
  input  logic             ne,
  input  logic [CNT_W-1:0] nfrq,
  input  logic             nfrq_wr,
  input  logic             lfsr_out,
  output logic             lfsr_rst,
  output logic             base,
  output logic             noise_bit,
  output logic             noise_upd
);

  localparam logic [3:0] INIT_LAST = 4'(INIT_CYC - 1);

  noise_state_e     state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [3:0]       init_cnt, init_cnt_nx;
  logic             base_nx, noise_q, noise_q_nx, upd_nx, lfsr_rst_nx;
  logic             pend, pend_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= INIT;
      cnt       <= '0;
      init_cnt  <= '0;
      base      <= 1'b0;
      noise_q   <= 1'b0;
      noise_upd <= 1'b0;
      lfsr_rst  <= 1'b1;
      pend      <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      init_cnt  <= init_cnt_nx;
      base      <= base_nx;
      noise_q   <= noise_q_nx;
      noise_upd <= upd_nx;
      lfsr_rst  <= lfsr_rst_nx;
      pend      <= pend_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    init_cnt_nx = init_cnt;
    base_nx     = base;
    noise_q_nx  = noise_q;
    upd_nx      = noise_upd;
    lfsr_rst_nx = lfsr_rst;
    pend_nx     = pend;
    case (state)
      // The power-up hold runs on raw clk so the LFSR is always seeded.
      INIT: begin
        init_cnt_nx = init_cnt + 4'd1;
        if (init_cnt == INIT_LAST) begin
          lfsr_rst_nx = 1'b0;
          cnt_nx      = nfrq;
          state_nx    = COUNT;
        end
      end
      COUNT: begin
        if (cen) begin
          if (nfrq_wr) begin
            cnt_nx = nfrq;
          end else if (zero) begin
            if (&cnt) begin
              base_nx  = ~base;
              cnt_nx   = nfrq;
              state_nx = SHIFT;
            end else begin
              cnt_nx = cnt + CNT_W'(1);
            end
          end
        end
      end
      SHIFT: begin
        if (cen) begin
          pend_nx  = pend | nfrq_wr;
          upd_nx   = 1'b1;
          state_nx = CAPTURE;
        end
      end
      CAPTURE: begin
        if (cen) begin
          noise_q_nx = lfsr_out;
          upd_nx     = 1'b0;
          pend_nx    = 1'b0;
          state_nx   = COUNT;
          // A register write seen while busy wins over the reload taken at the toggle.
          if (pend || nfrq_wr) cnt_nx = nfrq;
        end
      end
      default: state_nx = INIT;
    endcase
  end

  assign noise_bit = ne & noise_q;

endmodule

// File: tb/tb_jt51_noise_ctrl.sv
// Bench for jt51_noise_ctrl: a stand-in LFSR next to the DUT, randomized tick
// spacing, and a period/sequence reference computed from plain arithmetic.
module tb_jt51_noise_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cen, zero, ne, nfrq_wr;
  logic [4:0] nfrq;
  logic       lfsr_out, lfsr_rst, base, noise_bit, noise_upd;

  int n_checks = 0;
  int n_fail   = 0;
  int cap_idx  = 0;
  logic model_q = 1'b0;

  always #5 clk = ~clk;

  jt51_noise_ctrl #(.CNT_W(5), .INIT_CYC(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cen       (cen),
    .zero      (zero),
    .ne        (ne),
    .nfrq      (nfrq),
    .nfrq_wr   (nfrq_wr),
    .lfsr_out  (lfsr_out),
    .lfsr_rst  (lfsr_rst),
    .base      (base),
    .noise_bit (noise_bit),
    .noise_upd (noise_upd)
  );

  // Stand-in for the parent's LFSR: one shift per observed change of base.
  logic [16:0] bb;
  logic        last;
  always_ff @(posedge clk) begin
    if (lfsr_rst) begin
      bb   <= 17'd14220;
      last <= 1'b0;
    end else if (cen) begin
      last <= base;
      if (last != base) bb <= {bb[15:0], ~(bb[16] ^ bb[13])};
    end
  end
  assign lfsr_out = bb[16];

  // Top bit of the noise register after k steps from the seed.
  function automatic logic exp_noise(input int k);
    int unsigned v;
    v = 14220;
    for (int i = 0; i < k; i++)
      v = ((v * 2) % 131072) + (1 - (((v / 65536) + (v / 8192)) % 2));
    return ((v / 65536) % 2) == 1;
  endfunction

  task automatic step(input logic z, input logic w);
    cen = 1'b1; zero = z; nfrq_wr = w;
    @(posedge clk); #1;
    cen = 1'b0; zero = 1'b0; nfrq_wr = 1'b0;
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
  endtask

  task automatic tick(output bit toggled);
    logic b0;
    b0 = base;
    step(1'b1, 1'b0);
    toggled = (base !== b0);
    if (toggled) begin
      n_checks++;
      if (noise_upd !== 1'b0) begin
        n_fail++; $display("FAIL upd_in_shift got=%b want=0", noise_upd);
      end
      step(1'b0, 1'b0);
      cap_idx++;
      model_q = exp_noise(cap_idx);
      n_checks++;
      if (noise_upd !== 1'b1) begin
        n_fail++; $display("FAIL upd_pulse got=%b want=1", noise_upd);
      end
      step(1'b0, 1'b0);
      n_checks++;
      if (noise_upd !== 1'b0 || noise_bit !== (ne & model_q)) begin
        n_fail++;
        $display("FAIL capture[%0d] upd=%b bit=%b want upd=0 bit=%b",
                 cap_idx, noise_upd, noise_bit, ne & model_q);
      end
    end
  endtask

  task automatic measure(input int exp_ticks, input string name);
    int n;
    bit t;
    n = 0; t = 1'b0;
    while (!t && n < 40) begin
      if ($urandom_range(0, 3) == 0) step(1'b0, 1'b0);
      tick(t);
      n++;
    end
    n_checks++;
    if (!t || n != exp_ticks) begin
      n_fail++;
      $display("FAIL period_%s ticks=%0d toggled=%0b want ticks=%0d", name, n, t, exp_ticks);
    end
  endtask

  task automatic load(input logic [4:0] v);
    nfrq = v;
    step(1'b0, 1'b1);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; cen = 1'b0; zero = 1'b0; nfrq_wr = 1'b0; ne = 1'b1; nfrq = 5'd31;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (lfsr_rst !== 1'b1 || base !== 1'b0 || noise_bit !== 1'b0 || noise_upd !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_vals rst=%b base=%b bit=%b upd=%b want 1 0 0 0",
               lfsr_rst, base, noise_bit, noise_upd);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (lfsr_rst !== 1'b1 || base !== 1'b0 || noise_bit !== 1'b0) begin
      n_fail++; $display("FAIL init_hold1 rst=%b base=%b bit=%b want 1 0 0", lfsr_rst, base, noise_bit);
    end
    @(posedge clk); #1;
    n_checks++;
    if (lfsr_rst !== 1'b0) begin
      n_fail++; $display("FAIL init_release rst=%b want 0", lfsr_rst);
    end
    cap_idx = 0;
  endtask

  task automatic test_fast;
    ne = 1'b1;
    for (int i = 0; i < 10; i++) measure(1, "nfrq31");
  endtask

  task automatic test_period;
    load(5'd0);  measure(32, "nfrq0");
    load(5'd28); measure(4, "nfrq28");
    for (int i = 0; i < 6; i++) begin
      logic [4:0] v;
      v = 5'($urandom_range(12, 31));
      load(v);
      measure(32 - int'(v), "rand");
    end
  endtask

  task automatic test_ne;
    bit t;
    ne = 1'b1;
    load(5'd24);
    for (int i = 0; i < 3; i++) begin
      tick(t);
      n_checks++;
      if (t) begin n_fail++; $display("FAIL ne_early_toggle tick=%0d", i); end
    end
    ne = 1'b0; #1;
    n_checks++;
    if (noise_bit !== 1'b0) begin n_fail++; $display("FAIL ne_mask got=%b want=0", noise_bit); end
    ne = 1'b1; #1;
    n_checks++;
    if (noise_bit !== model_q) begin n_fail++; $display("FAIL ne_unmask got=%b want=%b", noise_bit, model_q); end
    ne = 1'b0;
    measure(5, "ne_phase");
    measure(8, "ne_off");
    for (int i = 0; i < 6; i++) begin
      ne = 1'($urandom_range(0, 1));
      measure(8, "ne_rand");
    end
    ne = 1'b1; #1;
    n_checks++;
    if (noise_bit !== model_q) begin n_fail++; $display("FAIL ne_restore got=%b want=%b", noise_bit, model_q); end
  endtask

  task automatic test_wr_zero;
    logic b0;
    ne = 1'b1;
    load(5'd20);
    b0 = base;
    nfrq = 5'd30;
    step(1'b1, 1'b1);
    n_checks++;
    if (base !== b0) begin n_fail++; $display("FAIL wr_priority base=%b want=%b", base, b0); end
    step(1'b1, 1'b0);
    n_checks++;
    if (base !== b0) begin n_fail++; $display("FAIL wr_tick1 base=%b want=%b", base, b0); end
    step(1'b1, 1'b0);
    n_checks++;
    if (base === b0) begin n_fail++; $display("FAIL wr_tick2 base=%b want=%b", base, ~b0); end
    nfrq = 5'd29;
    step(1'b0, 1'b1);
    cap_idx++;
    model_q = exp_noise(cap_idx);
    n_checks++;
    if (noise_upd !== 1'b1) begin n_fail++; $display("FAIL wr_shift_upd got=%b want=1", noise_upd); end
    step(1'b0, 1'b0);
    n_checks++;
    if (noise_bit !== model_q) begin n_fail++; $display("FAIL wr_shift_bit got=%b want=%b", noise_bit, model_q); end
    measure(3, "pending");
  endtask

  task automatic test_reset_mid;
    bit t;
    ne = 1'b1;
    load(5'd31);
    tick(t);
    step(1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (base !== 1'b0 || lfsr_rst !== 1'b1 || noise_bit !== 1'b0 || noise_upd !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset base=%b rst=%b bit=%b upd=%b want 0 1 0 0", base, lfsr_rst, noise_bit, noise_upd);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_checks++;
    if (lfsr_rst !== 1'b0) begin n_fail++; $display("FAIL mid_release rst=%b want 0", lfsr_rst); end
    cap_idx = 0;
    for (int i = 0; i < 6; i++) measure(1, "restart");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset;
    test_fast;
    test_period;
    test_ne;
    test_wr_zero;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
